// File: rtl/vga_pixel_fetch.sv
// VGA pixel fetch: scales column/row into a framebuffer address, reads video RAM
// and outputs 1-bit RGB with aligned syncs. Optional blink: VGA_PIXEL_BLINK_EN.
module vga_pixel_fetch #(
   parameter int X_WIDTH = 10,
   parameter int Y_WIDTH = 10,
   parameter int SCALE = 3,
   parameter int FB_COLS = 80,
   parameter int FB_ROWS = 60,
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 4,
   parameter logic [2:0] BG_COLOR = 3'b001,
   parameter int BLINK_BIT = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iPixelEn,
   input  logic [X_WIDTH-1:0]    iCol,
   input  logic [Y_WIDTH-1:0]    iRow,
   input  logic                  iDisplay,
   input  logic                  iHSync,
   input  logic                  iVSync,
   output logic [ADDR_WIDTH-1:0] oMemAddr,
   output logic                  oMemRdEn,
   input  logic [DATA_WIDTH-1:0] iMemData,
   output logic                  oRed,
   output logic                  oGreen,
   output logic                  oBlue,
   output logic                  oHSync,
   output logic                  oVSync,
   output logic [7:0]            oFrameCount
);

   logic        run_q;
   logic        en;
   logic [31:0] fc32;
   logic [31:0] fr32;
   logic [31:0] lin;
   logic        in_fb;
   logic [ADDR_WIDTH-1:0] addr_d;

   logic s1_disp, s1_infb, s1_hs, s1_vs;
   logic s2_disp, s2_infb, s2_hs, s2_vs;
   logic vs_seen;
   logic blink;
   logic [2:0] rgb_d;
   logic unused_bits;

   // Strobes are ignored until one Clock after reset release
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   assign en       = iPixelEn & run_q;
   assign oMemRdEn = iPixelEn;

   assign fc32  = 32'(iCol >> SCALE);
   assign fr32  = 32'(iRow >> SCALE);
   assign lin   = fr32 * 32'(FB_COLS) + fc32;
   assign in_fb = iDisplay
                  && (fc32 < 32'(FB_COLS))
                  && (fr32 < 32'(FB_ROWS));
   assign addr_d = in_fb ? lin[ADDR_WIDTH-1:0] : '0;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         oMemAddr <= '0;
         s1_disp  <= 1'b0;
         s1_infb  <= 1'b0;
         s1_hs    <= 1'b1;
         s1_vs    <= 1'b1;
      end else if (en) begin
         oMemAddr <= addr_d;
         s1_disp  <= iDisplay;
         s1_infb  <= in_fb;
         s1_hs    <= iHSync;
         s1_vs    <= iVSync;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         s2_disp <= 1'b0;
         s2_infb <= 1'b0;
         s2_hs   <= 1'b1;
         s2_vs   <= 1'b1;
      end else if (en) begin
         s2_disp <= s1_disp;
         s2_infb <= s1_infb;
         s2_hs   <= s1_hs;
         s2_vs   <= s1_vs;
      end
   end

   // vs_seen blocks counting a low vsync that is already present at reset release
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         vs_seen     <= 1'b0;
         oFrameCount <= 8'd0;
      end else if (en) begin
         vs_seen <= vs_seen | iVSync;
         if (vs_seen && s1_vs && !iVSync)
            oFrameCount <= oFrameCount + 8'd1;
      end
   end

   always_comb begin
      blink = 1'b0;
`ifdef VGA_PIXEL_BLINK_EN
      blink = iMemData[3] & oFrameCount[BLINK_BIT];
`endif
      if (!s2_disp)     rgb_d = 3'b000;
      else if (!s2_infb) rgb_d = BG_COLOR;
      else if (blink)    rgb_d = BG_COLOR;
      else               rgb_d = iMemData[2:0];
   end

   assign unused_bits = ^{lin[31:ADDR_WIDTH], iMemData};

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         oRed   <= 1'b0;
         oGreen <= 1'b0;
         oBlue  <= 1'b0;
         oHSync <= 1'b1;
         oVSync <= 1'b1;
      end else if (en) begin
         oRed   <= rgb_d[2];
         oGreen <= rgb_d[1];
         oBlue  <= rgb_d[0];
         oHSync <= s2_hs;
         oVSync <= s2_vs;
      end
   end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: the driver queues expected colour/syncs,
// the monitor checks them two strobes later.
module tb_vga_pixel_fetch;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        iPixelEn = 1'b0;
   logic [9:0]  iCol = '0;
   logic [9:0]  iRow = '0;
   logic        iDisplay = 1'b0;
   logic        iHSync = 1'b1;
   logic        iVSync = 1'b1;
   logic [12:0] oMemAddr;
   logic        oMemRdEn;
   logic [3:0]  iMemData = '0;
   logic        oRed, oGreen, oBlue;
   logic        oHSync, oVSync;
   logic [7:0]  oFrameCount;

   int errors = 0;
   int checks = 0;
   int nst = 0;
   bit live = 1'b0;
   logic [4:0] q[$];
   logic [4:0] last_e = 5'b00011;
   logic [3:0] mem [0:8191];

   vga_pixel_fetch dut (
      .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn),
      .iCol(iCol), .iRow(iRow), .iDisplay(iDisplay),
      .iHSync(iHSync), .iVSync(iVSync),
      .oMemAddr(oMemAddr), .oMemRdEn(oMemRdEn),
      .iMemData(iMemData),
      .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
      .oHSync(oHSync), .oVSync(oVSync),
      .oFrameCount(oFrameCount)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock)
      if (oMemRdEn) iMemData <= mem[oMemAddr];

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   always @(posedge Clock) begin
      if (iPixelEn && live) begin
         #1;
         nst++;
         if (nst >= 3) begin
            if (q.size() == 0) begin
               chk("queue_empty", 32'd0, 32'd1);
            end else begin
               last_e = q.pop_front();
               chk("rgb", {oRed, oGreen, oBlue}, last_e[4:2]);
               chk("hsync", oHSync, last_e[1]);
               chk("vsync", oVSync, last_e[0]);
            end
         end
      end
   end

   task automatic pix(input int col, input int row, input bit disp,
                      input bit hs, input bit vs, input logic [2:0] rgb);
      @(negedge Clock);
      iCol = col[9:0];
      iRow = row[9:0];
      iDisplay = disp;
      iHSync = hs;
      iVSync = vs;
      iPixelEn = 1'b1;
      q.push_back({rgb, hs, vs});
      @(negedge Clock);
      iPixelEn = 1'b0;
   endtask

   task automatic pixa(input int col, input int row, input bit disp,
                       input bit hs, input bit vs, input logic [2:0] rgb,
                       input int addr);
      pix(col, row, disp, hs, vs, rgb);
      chk("addr", oMemAddr, addr);
   endtask

   task automatic edges(input int n);
      for (int i = 0; i < n; i++) begin
         pix(700, 0, 1'b0, 1'b1, 1'b1, 3'b000);
         pix(700, 0, 1'b0, 1'b1, 1'b0, 3'b000);
      end
   endtask

   task automatic chk_reset();
      chk("rst_rgb", {oRed, oGreen, oBlue}, 3'b000);
      chk("rst_hs", oHSync, 1'b1);
      chk("rst_vs", oVSync, 1'b1);
      chk("rst_addr", oMemAddr, 0);
      chk("rst_fc", oFrameCount, 0);
   endtask

   initial begin
      logic [2:0] blink_rgb;
      for (int i = 0; i < 8192; i++) mem[i] = 4'h7;
      mem[82] = 4'h5;
      mem[4799] = 4'h3;
      mem[160] = 4'he;
`ifdef VGA_PIXEL_BLINK_EN
      blink_rgb = 3'b001;
`else
      blink_rgb = 3'b110;
`endif
      repeat (3) @(negedge Clock);
      chk_reset();

      // strobe in the Clock of reset release is dropped
      Reset = 1'b1;
      iCol = 10'd17;
      iRow = 10'd9;
      iDisplay = 1'b1;
      iPixelEn = 1'b1;
      @(negedge Clock);
      iPixelEn = 1'b0;
      chk("rel_addr", oMemAddr, 0);
      live = 1'b1;

      pixa(0, 0, 1, 1, 0, 3'b111, 0);
      chk("fc_no_edge", oFrameCount, 0);
      pixa(8, 0, 1, 1, 1, 3'b111, 1);
      pixa(16, 0, 1, 1, 0, 3'b111, 2);
      chk("fc_one", oFrameCount, 1);

      pixa(17, 9, 1, 1, 0, 3'b101, 82);
      pixa(639, 479, 1, 1, 0, 3'b011, 4799);
      pixa(700, 5, 0, 1, 0, 3'b000, 0);
      pixa(648, 8, 1, 1, 0, 3'b001, 0);
      pix(639, 479, 1, 0, 0, 3'b011);
      pix(648, 8, 1, 0, 0, 3'b001);
      pix(17, 9, 1, 0, 0, 3'b101);
      pix(0, 0, 1, 1, 0, 3'b111);
      pixa(17, 9, 1, 1, 0, 3'b101, 82);

      repeat (20) @(negedge Clock);
      chk("frz_rgb", {oRed, oGreen, oBlue}, 3'b101);
      chk("frz_hs", oHSync, 1'b0);
      chk("frz_vs", oVSync, 1'b0);
      chk("frz_addr", oMemAddr, 82);
      chk("frz_fc", oFrameCount, 1);

      live = 1'b0;
      #2;
      Reset = 1'b0;
      #1;
      chk_reset();
      q.delete();
      nst = 0;
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      live = 1'b1;

      edges(257);
      chk("fc_257", oFrameCount, 1);
      edges(15);
      chk("fc_16", oFrameCount, 16);
      pixa(0, 16, 1, 1, 0, blink_rgb, 160);
      pix(700, 0, 0, 1, 0, 3'b000);
      pix(700, 0, 0, 1, 0, 3'b000);
      edges(240);
      chk("fc_wrap", oFrameCount, 0);
      pixa(0, 16, 1, 1, 0, 3'b110, 160);
      pix(700, 0, 0, 1, 0, 3'b000);
      pix(700, 0, 0, 1, 0, 3'b000);
      repeat (2) @(negedge Clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
